// File: rtl/axi_lite_master.sv
// ============================================================================
// axi_lite_master : single-outstanding AXI4-Lite initiator (cmd/rsp -> AXI)
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_axi_clk,
  input  logic                  i_axi_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [31:0]           i_cmd_wdata,
  input  logic [3:0]            i_cmd_wstrb,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_write,
  output logic [31:0]           o_rsp_rdata,
  output logic [1:0]            o_rsp_resp,
  output logic                  o_busy,
  output logic                  o_timeout,
  input  logic                  i_timeout_clr,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  output logic [31:0]           o_wdata,
  output logic [3:0]            o_wstrb,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  input  logic [1:0]            i_bresp,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [1:0]            i_rresp,
  input  logic [31:0]           i_rdata
);

  localparam int              c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_WR   = 3'd1;
  localparam logic [2:0] c_WB   = 3'd2;
  localparam logic [2:0] c_RA   = 3'd3;
  localparam logic [2:0] c_RD   = 3'd4;
  localparam logic [2:0] c_RSP  = 3'd5;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic                  r_rsp_write;
  logic [31:0]           r_rsp_rdata;
  logic [1:0]            r_rsp_resp;
  logic [c_CNT_W-1:0]    r_tmo_cnt;
  logic                  r_timeout;

  logic w_aw_done;
  logic w_w_done;
  logic w_wr_done;
  logic w_ra_done;
  logic w_waiting;

  // A channel counts as done once its valid has already dropped or is handshaking now.
  assign w_aw_done = !r_awvalid || i_awready;
  assign w_w_done  = !r_wvalid  || i_wready;
  assign w_wr_done = (r_state == c_WR) && w_aw_done && w_w_done;
  assign w_ra_done = (r_state == c_RA) && i_arready;
  assign w_waiting = ((r_state == c_WB) && !i_bvalid) || ((r_state == c_RD) && !i_rvalid);

  always_ff @(posedge i_axi_clk) begin
    if (!i_axi_rst_n) begin
      r_state     <= c_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_cmd_valid) begin
            r_addr      <= i_cmd_addr;
            r_wdata     <= i_cmd_wdata;
            r_wstrb     <= i_cmd_wstrb;
            r_rsp_write <= i_cmd_write;
            if (i_cmd_write) begin
              r_state   <= c_WR;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= c_RA;
              r_arvalid <= 1'b1;
            end
          end
        end
        c_WR: begin
          if (i_awready) r_awvalid <= 1'b0;
          if (i_wready)  r_wvalid  <= 1'b0;
          if (w_wr_done) begin
            r_state  <= c_WB;
            r_bready <= 1'b1;
          end
        end
        c_WB: begin
          if (i_bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= i_bresp;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= c_RSP;
          end
        end
        c_RA: begin
          if (i_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= c_RD;
          end
        end
        c_RD: begin
          if (i_rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= i_rdata;
            r_rsp_resp  <= i_rresp;
            r_rsp_valid <= 1'b1;
            r_state     <= c_RSP;
          end
        end
        c_RSP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Watchdog only reports; the transfer keeps waiting for the slave.
  always_ff @(posedge i_axi_clk) begin
    if (!i_axi_rst_n) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_wr_done || w_ra_done) begin
        r_tmo_cnt <= '0;
      end else if (w_waiting && (r_tmo_cnt != c_CNT_MAX)) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (i_timeout_clr) begin
        r_timeout <= 1'b0;
      end else if (w_waiting && (r_tmo_cnt == c_CNT_LAST)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_cmd_ready = (r_state == c_IDLE);
  assign o_busy      = (r_state != c_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_write = r_rsp_write;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_resp  = r_rsp_resp;
  assign o_timeout   = r_timeout;
  assign o_awvalid   = r_awvalid;
  assign o_awaddr    = r_addr;
  assign o_wvalid    = r_wvalid;
  assign o_wdata     = r_wdata;
  assign o_wstrb     = r_wstrb;
  assign o_bready    = r_bready;
  assign o_arvalid   = r_arvalid;
  assign o_araddr    = r_addr;
  assign o_rready    = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_master.sv
// ============================================================================
// tb_axi_lite_master : randomized self-checking bench with reactive AXI slave
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_lite_master;

  localparam int AW  = 32;
  localparam int TMO = 8;

  logic          i_axi_clk     = 1'b0;
  logic          i_axi_rst_n   = 1'b0;
  logic          i_cmd_valid   = 1'b0;
  logic          o_cmd_ready;
  logic          i_cmd_write   = 1'b0;
  logic [AW-1:0] i_cmd_addr    = '0;
  logic [31:0]   i_cmd_wdata   = '0;
  logic [3:0]    i_cmd_wstrb   = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready   = 1'b0;
  logic          o_rsp_write;
  logic [31:0]   o_rsp_rdata;
  logic [1:0]    o_rsp_resp;
  logic          o_busy;
  logic          o_timeout;
  logic          i_timeout_clr = 1'b0;
  logic          o_awvalid;
  logic          i_awready     = 1'b0;
  logic [AW-1:0] o_awaddr;
  logic          o_wvalid;
  logic          i_wready      = 1'b0;
  logic [31:0]   o_wdata;
  logic [3:0]    o_wstrb;
  logic          i_bvalid      = 1'b0;
  logic          o_bready;
  logic [1:0]    i_bresp       = '0;
  logic          o_arvalid;
  logic          i_arready     = 1'b0;
  logic [AW-1:0] o_araddr;
  logic          i_rvalid      = 1'b0;
  logic          o_rready;
  logic [1:0]    i_rresp       = '0;
  logic [31:0]   i_rdata       = '0;

  always #5 i_axi_clk = ~i_axi_clk;

  axi_lite_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_axi_clk(i_axi_clk), .i_axi_rst_n(i_axi_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp), .o_busy(o_busy),
    .o_timeout(o_timeout), .i_timeout_clr(i_timeout_clr),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rresp(i_rresp), .i_rdata(i_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Slave behaviour knobs: wait cycles before each ready/valid.
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = '0;
  bit          got_aw = 0, got_w = 0, got_ar = 0;
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;

  // Monitor state
  int          cyc = 0, acc_cyc = 0, aw_cyc = 0, w_cyc = 0;
  int          n_acc = 0, n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  int          awv_cnt = 0, wv_cnt = 0, arv_cnt = 0, proto_viol = 0;
  logic [31:0] mon_awaddr = '0, mon_wdata = '0, mon_araddr = '0;
  logic [3:0]  mon_wstrb = '0;
  bit          p_aw = 0, p_w = 0, p_ar = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  logic [3:0]  p_wstrb = '0;

  always @(negedge i_axi_clk) begin
    if (o_awvalid) begin i_awready = (aw_wait >= aw_dly); aw_wait++; end
    else begin i_awready = 1'b0; aw_wait = 0; end
    if (o_wvalid) begin i_wready = (w_wait >= w_dly); w_wait++; end
    else begin i_wready = 1'b0; w_wait = 0; end
    if (o_arvalid) begin i_arready = (ar_wait >= ar_dly); ar_wait++; end
    else begin i_arready = 1'b0; ar_wait = 0; end
    if (got_aw && got_w) begin i_bvalid = (b_wait >= b_dly); i_bresp = s_bresp; b_wait++; end
    else begin i_bvalid = 1'b0; i_bresp = 2'b00; b_wait = 0; end
    if (got_ar) begin i_rvalid = (r_wait >= r_dly); i_rdata = s_rdata; i_rresp = s_rresp; r_wait++; end
    else begin i_rvalid = 1'b0; i_rdata = '0; i_rresp = 2'b00; r_wait = 0; end
  end

  always @(posedge i_axi_clk) begin
    cyc++;
    if (!i_axi_rst_n) begin
      p_aw = 0; p_w = 0; p_ar = 0;
    end else begin
      if (p_aw && (o_awvalid !== 1'b1 || o_awaddr !== p_awaddr)) proto_viol++;
      if (p_w && (o_wvalid !== 1'b1 || o_wdata !== p_wdata || o_wstrb !== p_wstrb)) proto_viol++;
      if (p_ar && (o_arvalid !== 1'b1 || o_araddr !== p_araddr)) proto_viol++;
      p_aw = o_awvalid && !i_awready; p_awaddr = o_awaddr;
      p_w  = o_wvalid && !i_wready;   p_wdata = o_wdata; p_wstrb = o_wstrb;
      p_ar = o_arvalid && !i_arready; p_araddr = o_araddr;
      if (i_cmd_valid && o_cmd_ready) begin
        acc_cyc = cyc; n_acc++; awv_cnt = 0; wv_cnt = 0; arv_cnt = 0;
      end
      if (o_awvalid) awv_cnt++;
      if (o_wvalid)  wv_cnt++;
      if (o_arvalid) arv_cnt++;
      if (o_awvalid && i_awready) begin n_aw++; aw_cyc = cyc; mon_awaddr = o_awaddr; got_aw = 1; end
      if (o_wvalid && i_wready) begin
        n_w++; w_cyc = cyc; mon_wdata = o_wdata; mon_wstrb = o_wstrb; got_w = 1;
      end
      if (i_bvalid && o_bready) begin n_b++; got_aw = 0; got_w = 0; end
      if (o_arvalid && i_arready) begin n_ar++; mon_araddr = o_araddr; got_ar = 1; end
      if (i_rvalid && o_rready) begin n_r++; got_ar = 0; end
    end
  end

  task automatic step();
    @(negedge i_axi_clk);
    #1;
  endtask

  task automatic set_slave(input int awd, input int wd, input int bd, input int ard, input int rd);
    aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
  endtask

  // Issues one command, waits for its response, holds i_rsp_ready low for
  // 'hold' cycles, then consumes it. Returns observations only.
  task automatic drive_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int hold, input bit keep_cmd,
                           output int lat, output logic rwr, output logic [31:0] rdat,
                           output logic [1:0] rresp, output bit stable, output bit hung);
    int guard;
    stable = 1; hung = 0; lat = 0; rwr = 1'b0; rdat = '0; rresp = '0;
    i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_addr = addr;
    i_cmd_wdata = wdata; i_cmd_wstrb = strb;
    guard = 0;
    while (o_cmd_ready !== 1'b1 && guard < 50) begin step(); guard++; end
    step();
    i_cmd_valid = keep_cmd;
    lat = 1;
    while (o_rsp_valid !== 1'b1 && lat < 200) begin step(); lat++; end
    if (o_rsp_valid !== 1'b1) begin
      hung = 1; i_cmd_valid = 1'b0;
      return;
    end
    rwr = o_rsp_write; rdat = o_rsp_rdata; rresp = o_rsp_resp;
    for (int k = 0; k < hold; k++) begin
      step();
      if (o_rsp_valid !== 1'b1 || o_rsp_write !== rwr || o_rsp_rdata !== rdat ||
          o_rsp_resp !== rresp || o_cmd_ready !== 1'b0 || o_awvalid !== 1'b0 ||
          o_wvalid !== 1'b0 || o_arvalid !== 1'b0 || o_bready !== 1'b0 || o_rready !== 1'b0)
        stable = 0;
    end
    i_cmd_valid = 1'b0;
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_axi_rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rsp_valid, o_timeout, o_busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rsp_valid, o_timeout, o_busy});
    end
    checks++;
    if (o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b required 1", o_cmd_ready);
    end
    checks++;
    if ({o_awaddr, o_araddr, o_wdata, o_wstrb, o_rsp_rdata, o_rsp_resp, o_rsp_write} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0",
               {o_awaddr, o_araddr, o_wdata, o_wstrb, o_rsp_rdata, o_rsp_resp, o_rsp_write});
    end
    i_axi_rst_n = 1'b1;
    step();
  endtask

  task automatic test_zero_wait_write();
    int lat; logic rwr; logic [31:0] rd; logic [1:0] rs; bit st, hg; int nb0;
    set_slave(0, 0, 0, 0, 0); s_bresp = 2'b00;
    nb0 = n_b;
    drive_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, lat, rwr, rd, rs, st, hg);
    checks++;
    if (hg || lat !== 3) begin errors++; $display("FAIL zw_latency: got %0d required 3", lat); end
    checks++;
    if ({rwr, rd, rs} !== {1'b1, 32'h0, 2'b00}) begin
      errors++; $display("FAIL zw_rsp: got wr=%b rdata=%h resp=%b required wr=1 rdata=0 resp=00", rwr, rd, rs);
    end
    checks++;
    if (aw_cyc !== w_cyc || (aw_cyc - acc_cyc) !== 1) begin
      errors++; $display("FAIL zw_aw_w_same: got aw=+%0d w=+%0d required +1/+1", aw_cyc - acc_cyc, w_cyc - acc_cyc);
    end
    checks++;
    if (mon_awaddr !== 32'h10 || mon_wdata !== 32'hDEADBEEF || mon_wstrb !== 4'hF || (n_b - nb0) !== 1) begin
      errors++;
      $display("FAIL zw_channels: got addr=%h data=%h strb=%h nb=%0d required 10/deadbeef/f/1",
               mon_awaddr, mon_wdata, mon_wstrb, n_b - nb0);
    end
  endtask

  task automatic test_split_aw_w();
    int lat; logic rwr; logic [31:0] rd; logic [1:0] rs; bit st, hg; int nb0;
    set_slave(4, 0, 0, 0, 0); s_bresp = 2'b01;
    nb0 = n_b;
    drive_txn(1'b1, 32'h44, 32'hCAFEF00D, 4'h5, 0, 1'b0, lat, rwr, rd, rs, st, hg);
    checks++;
    if ((w_cyc - acc_cyc) !== 1 || (aw_cyc - acc_cyc) !== 5) begin
      errors++; $display("FAIL split_hs_cycles: got aw=+%0d w=+%0d required +5/+1", aw_cyc - acc_cyc, w_cyc - acc_cyc);
    end
    checks++;
    if (awv_cnt !== 5 || wv_cnt !== 1) begin
      errors++; $display("FAIL split_valid_len: got aw=%0d w=%0d required 5/1", awv_cnt, wv_cnt);
    end
    checks++;
    if (hg || lat !== 7 || (n_b - nb0) !== 1 || {rwr, rd, rs} !== {1'b1, 32'h0, 2'b01}) begin
      errors++;
      $display("FAIL split_rsp: got lat=%0d nb=%0d wr=%b rdata=%h resp=%b required 7/1/1/0/01",
               lat, n_b - nb0, rwr, rd, rs);
    end
  endtask

  task automatic test_read_wait();
    int lat; logic rwr; logic [31:0] rd; logic [1:0] rs; bit st, hg;
    set_slave(0, 0, 0, 0, 4); s_rdata = 32'h12345678; s_rresp = 2'b10;
    drive_txn(1'b0, 32'h04, 32'h0, 4'h0, 0, 1'b0, lat, rwr, rd, rs, st, hg);
    checks++;
    if ({rwr, rd, rs} !== {1'b0, 32'h12345678, 2'b10}) begin
      errors++; $display("FAIL rd_rsp: got wr=%b rdata=%h resp=%b required 0/12345678/10", rwr, rd, rs);
    end
    checks++;
    if (hg || lat !== 7 || mon_araddr !== 32'h04) begin
      errors++; $display("FAIL rd_timing: got lat=%0d araddr=%h required 7/00000004", lat, mon_araddr);
    end
  endtask

  task automatic test_timeout();
    int guard, waits;
    bit clr_ok;
    set_slave(0, 0, 20, 0, 0); s_bresp = 2'b00;
    i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 32'h80; i_cmd_wdata = 32'h1; i_cmd_wstrb = 4'h1;
    step();
    i_cmd_valid = 1'b0;
    guard = 0;
    while (o_bready !== 1'b1 && guard < 50) begin step(); guard++; end
    waits = 0; guard = 0;
    while (o_rsp_valid !== 1'b1 && guard < 60) begin
      checks++;
      if (o_timeout !== (waits >= TMO)) begin
        errors++; $display("FAIL tmo_wait%0d: got %b required %b", waits, o_timeout, waits >= TMO);
      end
      if (o_bready === 1'b1 && i_bvalid !== 1'b1) waits++;
      step(); guard++;
    end
    checks++;
    if (o_rsp_valid !== 1'b1 || o_timeout !== 1'b1) begin
      errors++; $display("FAIL tmo_complete: got rsp=%b tmo=%b required 1/1", o_rsp_valid, o_timeout);
    end
    i_rsp_ready = 1'b1; step(); i_rsp_ready = 1'b0;
    checks++;
    if (o_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b required 1", o_timeout); end
    i_timeout_clr = 1'b1; step(); i_timeout_clr = 1'b0;
    checks++;
    if (o_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b required 0", o_timeout); end

    // Clear held across the saturating wait: clear must win the simultaneous set.
    set_slave(0, 0, 0, 0, 12); s_rdata = 32'hA5A5A5A5; s_rresp = 2'b00;
    i_timeout_clr = 1'b1;
    i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 32'h84;
    step();
    i_cmd_valid = 1'b0;
    clr_ok = 1; guard = 0;
    while (o_rsp_valid !== 1'b1 && guard < 60) begin
      if (o_timeout !== 1'b0) clr_ok = 0;
      step(); guard++;
    end
    checks++;
    if (!clr_ok || o_timeout !== 1'b0 || o_rsp_rdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL tmo_clr_priority: got ok=%b rdata=%h required 1/a5a5a5a5", clr_ok, o_rsp_rdata);
    end
    i_timeout_clr = 1'b0;
    i_rsp_ready = 1'b1; step(); i_rsp_ready = 1'b0;
  endtask

  task automatic test_rsp_hold();
    int lat; logic rwr; logic [31:0] rd; logic [1:0] rs; bit st, hg; int acc0, aw0;
    set_slave(0, 0, 0, 0, 0); s_bresp = 2'b11;
    acc0 = n_acc; aw0 = n_aw;
    drive_txn(1'b1, 32'h100, 32'h0BADF00D, 4'hC, 10, 1'b1, lat, rwr, rd, rs, st, hg);
    checks++;
    if (hg || !st) begin errors++; $display("FAIL hold_stable: got stable=%b hung=%b required 1/0", st, hg); end
    checks++;
    if ((n_acc - acc0) !== 1 || (n_aw - aw0) !== 1 || {rwr, rd, rs} !== {1'b1, 32'h0, 2'b11}) begin
      errors++;
      $display("FAIL hold_no_new: got acc=%0d aw=%0d wr=%b rdata=%h resp=%b required 1/1/1/0/11",
               n_acc - acc0, n_aw - aw0, rwr, rd, rs);
    end
  endtask

  task automatic test_reset_mid();
    int guard, nb0;
    bit idle_ok;
    set_slave(0, 0, 1000, 0, 0);
    i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 32'h20; i_cmd_wdata = 32'h55; i_cmd_wstrb = 4'hF;
    step();
    i_cmd_valid = 1'b0;
    guard = 0;
    while (o_bready !== 1'b1 && guard < 50) begin step(); guard++; end
    step(); step();
    checks++;
    if (o_bready !== 1'b1) begin errors++; $display("FAIL mid_in_wb: got bready=%b required 1", o_bready); end
    nb0 = n_b;
    i_axi_rst_n = 1'b0;
    step();
    checks++;
    if ({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rsp_valid, o_busy, o_cmd_ready} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL mid_reset: got %b required 00000001",
               {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rsp_valid, o_busy, o_cmd_ready});
    end
    i_axi_rst_n = 1'b1;
    b_dly = 0;
    idle_ok = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (o_rsp_valid !== 1'b0 || o_bready !== 1'b0 || o_busy !== 1'b0 || o_cmd_ready !== 1'b1) idle_ok = 0;
    end
    checks++;
    if (!idle_ok || (n_b - nb0) !== 0) begin
      errors++; $display("FAIL mid_late_b: got idle=%b nb=%0d required 1/0", idle_ok, n_b - nb0);
    end
    got_aw = 0; got_w = 0;
    step(); step();
  endtask

  task automatic test_random();
    int lat, exp_lat, awd, wd, bd, ard, rd, hold;
    logic rwr; logic [31:0] rdat; logic [1:0] rrs; bit st, hg;
    bit wr; logic [31:0] addr, wdata; logic [3:0] strb;
    int naw0, nw0, nb0, nar0, nr0;
    logic [34:0] exp_rsp;
    for (int t = 0; t < 40; t++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = $urandom & 32'hFFFF_FFFC;
      wdata = $urandom;
      strb  = 4'($urandom_range(0, 15));
      awd = $urandom_range(0, 4); wd = $urandom_range(0, 4); bd = $urandom_range(0, 5);
      ard = $urandom_range(0, 4); rd = $urandom_range(0, 5); hold = $urandom_range(0, 3);
      s_bresp = 2'($urandom_range(0, 3)); s_rresp = 2'($urandom_range(0, 3)); s_rdata = $urandom;
      set_slave(awd, wd, bd, ard, rd);
      naw0 = n_aw; nw0 = n_w; nb0 = n_b; nar0 = n_ar; nr0 = n_r;
      drive_txn(wr, addr, wdata, strb, hold, 1'b0, lat, rwr, rdat, rrs, st, hg);
      exp_lat = wr ? 3 + ((awd > wd) ? awd : wd) + bd : 3 + ard + rd;
      exp_rsp = wr ? {1'b1, 32'h0, s_bresp} : {1'b0, s_rdata, s_rresp};
      checks++;
      if (hg || lat !== exp_lat) begin
        errors++; $display("FAIL rnd%0d_latency: got %0d required %0d", t, lat, exp_lat);
      end
      checks++;
      if ({rwr, rdat, rrs} !== exp_rsp) begin
        errors++; $display("FAIL rnd%0d_rsp: got %h required %h", t, {rwr, rdat, rrs}, exp_rsp);
      end
      checks++;
      if (!st || o_timeout !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_stable: got stable=%b tmo=%b required 1/0", t, st, o_timeout);
      end
      checks++;
      if (wr) begin
        if ((n_aw - naw0) !== 1 || (n_w - nw0) !== 1 || (n_b - nb0) !== 1 || (n_ar - nar0) !== 0 ||
            mon_awaddr !== addr || mon_wdata !== wdata || mon_wstrb !== strb ||
            awv_cnt !== awd + 1 || wv_cnt !== wd + 1) begin
          errors++;
          $display("FAIL rnd%0d_wr_chan: got addr=%h data=%h strb=%h awv=%0d wv=%0d required %h/%h/%h/%0d/%0d",
                   t, mon_awaddr, mon_wdata, mon_wstrb, awv_cnt, wv_cnt, addr, wdata, strb, awd + 1, wd + 1);
        end
      end else begin
        if ((n_ar - nar0) !== 1 || (n_r - nr0) !== 1 || (n_aw - naw0) !== 0 ||
            mon_araddr !== addr || arv_cnt !== ard + 1) begin
          errors++;
          $display("FAIL rnd%0d_rd_chan: got araddr=%h arv=%0d required %h/%0d", t, mon_araddr, arv_cnt, addr, ard + 1);
        end
      end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_viol !== 0) begin
      errors++; $display("FAIL axi_stability: got %0d violations required 0", proto_viol);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_split_aw_w();
    test_read_wait();
    test_timeout();
    test_rsp_hold();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
